// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Instruction-memory request/acknowledge bus between the
//                fetch stage (master) and instruction memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if #(
  parameter int INSTR_W = 24,
  parameter int PC_W    = 8
);
  logic               mem_req;
  logic [PC_W-1:0]    mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_data;
  logic               mem_err;

  // Fetch side: issues requests, receives the one-cycle response
  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data,
    input  mem_err
  );

  // Memory side: observes requests, returns data/error with ack
  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data,
    output mem_err
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Pipeline stage 0. Holds the PC, fetches instruction words
//                over a req/ack bus and presents {valid, err, pc, instr}
//                to psr0. Applies taken-branch redirects from later stages.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int            INSTR_W  = 24,
  parameter int            PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  localparam int           WORD_W   = INSTR_W + PC_W + 2
) (
  input  wire logic              clk,
  input  wire logic              clr,
  input  wire logic              en,
  input  wire logic              adv,
  input  wire logic              br_taken,
  input  wire logic [PC_W-1:0]   br_target,
  fetch_stage_if.master          mem,
  output logic                   f_valid,
  output logic [WORD_W-1:0]      f_word
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_WAIT  = 3'd1,
    S_DRAIN = 3'd2,
    S_VALID = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t              r_state;
  logic [PC_W-1:0]     r_pc;
  logic                r_mem_req;
  logic [PC_W-1:0]     r_mem_addr;
  logic                r_f_valid;
  logic [WORD_W-1:0]   r_f_word;

  assign mem.mem_req  = r_mem_req;
  assign mem.mem_addr = r_mem_addr;
  assign f_valid      = r_f_valid;
  assign f_word       = r_f_word;

  // Fetch sequencer: PC, memory request and presented word all update here
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_f_valid  <= 1'b0;
      r_f_word   <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          // A redirect wins over starting a request; the request for the
          // new target goes out on the following cycle.
          if (br_taken) begin
            r_pc <= br_target;
          end else if (en) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_pc;
            r_state    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (mem.mem_ack) begin
            r_mem_req <= 1'b0;
            if (br_taken) begin
              // Returned word belongs to the wrong path: discard it.
              r_pc    <= br_target;
              r_state <= S_FETCH;
            end else begin
              r_f_word  <= {1'b1, mem.mem_err, r_pc, mem.mem_data};
              r_f_valid <= 1'b1;
              r_pc      <= r_pc + PC_W'(1);
              r_state   <= mem.mem_err ? S_HALT : S_VALID;
            end
          end else if (br_taken) begin
            // Bus transaction must still complete with a stable address.
            r_pc    <= br_target;
            r_state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          // Newest redirect target wins while the stale access drains.
          if (br_taken) begin
            r_pc <= br_target;
          end
          if (mem.mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= S_FETCH;
          end
        end

        S_VALID: begin
          // Accepted by psr0 or squashed by a redirect: either way the word
          // leaves; a simultaneous adv+redirect counts as accepted.
          if (adv || br_taken) begin
            r_f_valid <= 1'b0;
            r_f_word  <= '0;
            r_state   <= S_FETCH;
            if (br_taken) begin
              r_pc <= br_target;
            end
          end
        end

        S_HALT: begin
          // Only a redirect (or clr) restarts fetching after a bus error.
          if (br_taken) begin
            r_f_valid <= 1'b0;
            r_f_word  <= '0;
            r_pc      <= br_target;
            r_state   <= S_FETCH;
          end else if (adv && r_f_valid) begin
            r_f_valid <= 1'b0;
            r_f_word  <= '0;
          end
        end

        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
